mux_pipe: RTL
=============

Name: mux_pipe

Overview:
- Parametrised, registered N-way operand select with a valid/ready handshake on both sides.
- Successor to the combinational 2/3/4-input selects. Generalises data width and channel count, and adds a 1-cycle output register with a 2-entry skid buffer, so a select point can sit on a pipeline boundary without a combinational ready path.
- Used between decode/forwarding logic and the execute stage.

Parameters:
- WIDTH, 32, data width of each channel (matches instruction/word size).
- N_IN, 4, number of input channels, 2..16.
- SEL_W, $clog2(N_IN), select width; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_data  input  N_IN*WIDTH  packed channels; channel k is in_data[k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index, sampled with in_data when the input handshake fires.
- in_valid  input  1  upstream has data and sel.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected channel.
- out_err  output  1  entry was captured with sel >= N_IN.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=EMPTY, out_valid=0, out_data=0, out_err=0, in_ready=1 after reset deasserts. Reset mid-transfer discards all entries.
- Transfer rules:
  - Input transfer fires when in_valid && in_ready.
  - Output transfer fires when out_valid && out_ready.
  - Selected word = channel[sel] if sel < N_IN, else 0 with err=1.
- Storage: main register (drives outputs) and skid register.
- in_ready = (state != FULL) && !flush. It is registered-state-only, with no combinational path from out_ready.
- State machine:
  - EMPTY: input transfer -> load main, go ONE.
  - ONE:
    - input and output both fire -> main reloads with new word, stay ONE.
    - input only -> load skid, go FULL.
    - output only -> go EMPTY.
    - neither -> hold.
  - FULL:
    - output fires -> main <= skid, go ONE.
    - otherwise hold.
    - No input accepted in FULL.
- Latency: 1 cycle from input transfer to out_valid when downstream is not stalled. Throughput is 1 word/cycle sustained.
- Ordering: strict FIFO. The skid entry is never presented before main.
- Hold rule: while out_valid && !out_ready, out_data and out_err are stable cycle-to-cycle.
- flush:
  - Next state EMPTY, out_valid=0 next cycle, out_data/out_err cleared to 0.
  - An input presented during flush is not accepted (in_ready=0).
  - flush has priority over simultaneous output transfer; the transfer still completes downstream in that cycle.
- sel is only sampled at an input transfer; changes at other times have no effect.

Optional Feature:
- Macro MUX_PIPE_BYPASS_EN.
- Defined: in EMPTY with out_ready=1 and no flush, an input transfer passes straight to the outputs in the same cycle (out_valid=in_valid, out_data/out_err from the current sel) and nothing is stored. Latency is 0 in that case. in_ready is unchanged (still registered-state-only). If out_ready=0 in EMPTY, the word loads main as normal.
- Undefined: no bypass; latency is always 1 cycle.

Test Plan:
- Reset then stream: N_IN=4, WIDTH=32, channels = 0x11111111..0x44444444. Send sel 0,1,2,3 on 4 consecutive cycles with out_ready=1 -> out_valid from cycle 1, out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order, in_ready constantly 1.
- Backpressure: out_ready=0, send sel=2 then sel=1 -> state FULL, in_ready=0 on 3rd cycle, out_data holds 0x33333333. Release out_ready -> 0x33333333 then 0x22222222 delivered, in_ready returns 1 one cycle after the first pop.
- Out-of-range: N_IN=3, sel=3 -> out_data=0, out_err=1. The next entry with sel=0 has out_err=0.
- Flush in FULL: two entries buffered, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither buffered word nor the flushed-cycle input ever appears.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> out_valid=0 and out_data=0 immediately without a clock edge, and the state is EMPTY when rst_n rises.
- Bypass (MUX_PIPE_BYPASS_EN defined): EMPTY, out_ready=1, in_valid=1, sel=1 -> out_valid=1, out_data=channel1 in the same cycle. Without the macro, the same stimulus gives out_valid one cycle later.

Source files
------------

// File: rtl/mux_pipe.sv
// Registered N-way operand select with valid/ready on both sides and a 2-entry skid buffer.
// Optional same-cycle bypass from EMPTY is enabled by defining MUX_PIPE_BYPASS_EN.
module mux_pipe #(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_err_q, main_err_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             bypass;
    logic             in_fire;
    logic             out_fire;

    // Out-of-range selects return zero and flag the entry instead of aliasing a channel.
    always_comb begin
        sel_data = '0;
        sel_err  = (int'(sel) >= N_IN);
        for (int k = 0; k < N_IN; k++) begin
            if (int'(sel) == k) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_PIPE_BYPASS_EN
    assign bypass = (state_q == EMPTY) && out_ready && !flush && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = (state_q != FULL) && !flush;
    assign out_valid = (state_q != EMPTY) || bypass;
    assign out_data  = bypass ? sel_data : main_data_q;
    assign out_err   = bypass ? sel_err  : main_err_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_err_d  = 1'b0;
            skid_data_d = '0;
            skid_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire && !bypass) begin
                        main_data_d = sel_data;
                        main_err_d  = sel_err;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = sel_data;
                        main_err_d  = sel_err;
                    end else if (in_fire) begin
                        skid_data_d = sel_data;
                        skid_err_d  = sel_err;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid always holds the younger word, so it moves up only after main leaves.
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule
